// File: rtl/rtlola_cycle_offset_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rtlola_cycle_offset_monitor
// Brief    : Runtime monitor for a := x + c.offset(-1, 0); b := a + x;
//            c := b - 1.  Four-phase frame, one evaluation per frame.
// Revision : 1.0 - initial release
// ============================================================================
module rtlola_cycle_offset_monitor #(
  parameter int DW     = 64,
  parameter int PHASES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] x,
  input  logic                 newX,
  output logic                 outputPhase,
  output logic signed [DW-1:0] a,
  output logic                 enA,
  output logic signed [DW-1:0] b,
  output logic                 enB,
  output logic signed [DW-1:0] c,
  output logic                 enC
);

  localparam int C_STW = $clog2(PHASES);
  localparam logic signed [DW-1:0] C_ONE = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [C_STW-1:0] {
    S_SAMPLE  = C_STW'(0),
    S_EVAL_A  = C_STW'(1),
    S_EVAL_BC = C_STW'(2),
    S_OUTPUT  = C_STW'(3)
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic signed [DW-1:0] r_x;
  logic                 r_pend;
  logic signed [DW-1:0] r_an;
  logic signed [DW-1:0] r_cprev;
  logic signed [DW-1:0] r_a;
  logic signed [DW-1:0] r_b;
  logic signed [DW-1:0] r_c;
  logic signed [DW-1:0] w_bn;
  logic signed [DW-1:0] w_cn;
  logic                 w_out;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_SAMPLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and frame outputs
  always_comb begin
    w_state_nxt = r_state;
    w_out       = 1'b0;
    if (en) begin
      case (r_state)
        S_SAMPLE:  w_state_nxt = S_EVAL_A;
        S_EVAL_A:  w_state_nxt = S_EVAL_BC;
        S_EVAL_BC: w_state_nxt = S_OUTPUT;
        default:   w_state_nxt = S_SAMPLE;
      endcase
    end
    if (r_state == S_OUTPUT) begin
      w_out = 1'b1;
    end
  end

  // b and c settle combinationally in one clock from the registered a_n
  assign w_bn = r_an + r_x;
  assign w_cn = w_bn - C_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x     <= '0;
      r_pend  <= 1'b0;
      r_an    <= '0;
      r_cprev <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else if (en) begin
      case (r_state)
        S_SAMPLE: begin
          r_x    <= x;
          r_pend <= newX;
        end
        S_EVAL_A: begin
          if (r_pend) begin
            r_an <= r_x + r_cprev;
          end
        end
        S_EVAL_BC: begin
          if (r_pend) begin
            r_a <= r_an;
            r_b <= w_bn;
            r_c <= w_cn;
          end
        end
        default: begin
          // The offset memory only advances on real events, not on every frame.
          if (r_pend) begin
            r_cprev <= r_c;
          end
        end
      endcase
    end
  end

  assign outputPhase = w_out;
  assign enA         = w_out & r_pend;
  assign enB         = w_out & r_pend;
  assign enC         = w_out & r_pend;
  assign a           = r_a;
  assign b           = r_b;
  assign c           = r_c;

endmodule
`default_nettype wire

// File: tb/tb_rtlola_cycle_offset_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtlola_cycle_offset_monitor
// Brief    : Directed self-checking bench for rtlola_cycle_offset_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtlola_cycle_offset_monitor;

  logic        clk;
  logic        rst;
  logic        en;
  logic [63:0] x;
  logic        newX;
  logic        outputPhase;
  logic [63:0] a;
  logic        enA;
  logic [63:0] b;
  logic        enB;
  logic [63:0] c;
  logic        enC;

  int n_checks = 0;
  int n_fail   = 0;

  rtlola_cycle_offset_monitor #(.DW(64), .PHASES(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .x           (x),
    .newX        (newX),
    .outputPhase (outputPhase),
    .a           (a),
    .enA         (enA),
    .b           (b),
    .enB         (enB),
    .c           (c),
    .enC         (enC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT in SAMPLE; returns at a negedge in SAMPLE.
  // Inputs are scrambled after the sample edge, and en is dropped for `stall`
  // clocks in EVAL_A and again in OUTPUT.
  task automatic frame(input string tag, input logic [63:0] xv, input logic nv,
                       input int stall, input logic [63:0] ea, input logic [63:0] eb,
                       input logic [63:0] ec);
    x    = xv;
    newX = nv;
    @(posedge clk);
    @(negedge clk);
    x    = ~xv;
    newX = ~nv;
    check({tag, "_phase_eval"}, {63'd0, outputPhase}, 64'd0);
    if (stall > 0) begin
      en = 1'b0;
      repeat (stall) @(negedge clk);
      en = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_phase"}, {63'd0, outputPhase}, 64'd1);
    check({tag, "_en"}, {61'd0, enA, enB, enC}, {61'd0, nv, nv, nv});
    check({tag, "_a"}, a, ea);
    check({tag, "_b"}, b, eb);
    check({tag, "_c"}, c, ec);
    if (stall > 0) begin
      en = 1'b0;
      repeat (stall) @(negedge clk);
      check({tag, "_stall_phase"}, {63'd0, outputPhase}, 64'd1);
      check({tag, "_stall_a"}, a, ea);
      en = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_post_phase"}, {63'd0, outputPhase}, 64'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    check("rst_phase", {63'd0, outputPhase}, 64'd0);
    check("rst_abc", a | b | c, 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b1;
    x    = 64'd0;
    newX = 1'b1;
    // Reset held with toggling inputs: everything stays cleared
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      x = 64'(i * 3 + 1);
      check("hold_phase", {63'd0, outputPhase}, 64'd0);
      check("hold_abc", a | b | c, 64'd0);
      check("hold_en", {61'd0, enA, enB, enC}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    frame("ev1", 64'd1, 1'b1, 0, 64'd1, 64'd2, 64'd1);
    frame("ev2", 64'd2, 1'b1, 2, 64'd3, 64'd5, 64'd4);
    frame("ev3", 64'd3, 1'b1, 0, 64'd7, 64'd10, 64'd9);
    frame("idle", 64'd55, 1'b0, 0, 64'd7, 64'd10, 64'd9);
    frame("ev4", 64'd1, 1'b1, 1, 64'd10, 64'd11, 64'd10);

    // Reset mid-frame discards the partial event and the offset memory
    x    = 64'd7;
    newX = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    pulse_reset();
    frame("ev5", 64'd5, 1'b1, 0, 64'd5, 64'd10, 64'd9);

    // Overflow wrap with c_prev = 1
    pulse_reset();
    frame("ev6", 64'd1, 1'b1, 0, 64'd1, 64'd2, 64'd1);
    frame("wrap", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0,
          64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
